// File: rtl/irq_pkg.sv
// Shared definitions for the 6502 interrupt controller: register offsets,
// source count, VECTOR/NMICTL field positions and the priority helper.
package irq_pkg;

  localparam int NUM_SRC = 8;

  typedef enum logic [2:0] {
    OFF_PEND   = 3'd0,
    OFF_ENABLE = 3'd1,
    OFF_MODE   = 3'd2,
    OFF_VECTOR = 3'd3,
    OFF_NMICTL = 3'd4,
    OFF_SWSET  = 3'd5,
    OFF_RSVD6  = 3'd6,
    OFF_RSVD7  = 3'd7
  } reg_off_e;

  localparam int VEC_ANY_BIT = 7;
  localparam int VEC_IDX_LSB = 0;
  localparam int VEC_IDX_W   = 3;
  localparam int VEC_IDX_MSB = VEC_IDX_LSB + VEC_IDX_W - 1;

  localparam int NMICTL_EN_BIT   = 0;
  localparam int NMICTL_PEND_BIT = 1;

  // Lowest-numbered set bit wins; returns 0 when nothing is set.
  function automatic logic [VEC_IDX_W-1:0] lowest_index(input logic [NUM_SRC-1:0] v);
    lowest_index = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (v[i]) lowest_index = VEC_IDX_W'(i);
    end
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Two-flop synchroniser for asynchronous request lines, followed by a
// third flop that remembers the previous synchronised value for rising-edge detection.
module irq_sync_edge #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] meta_d, meta_q;
  logic [WIDTH-1:0] sync_d, sync_q;
  logic [WIDTH-1:0] prev_d, prev_q;

  always_comb begin
    meta_d = async_in;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign sync_out = sync_q;
  assign rise     = sync_q & ~prev_q;

endmodule

// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller feeding the 6502 irq/nmi inputs:
// eight maskable sources with level/edge mode plus one gated NMI source.
module irq_ctrl
  import irq_pkg::*;
#(
  parameter logic [15:0] BASE = 16'hD000
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic [15:0]  addr,
  input  logic         rw,
  input  logic [7:0]   din,
  output logic [7:0]   dout,
  output logic         dout_en,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic         nmi_src,
  output logic         irq,
  output logic         nmi
);

  logic [NUM_SRC-1:0] src_sync, src_rise;
  logic               nmi_sync, nmi_rise;

  irq_sync_edge #(.WIDTH(NUM_SRC)) u_irq_sync (
    .clk      (clk),
    .rst_n    (clr_n),
    .async_in (irq_src),
    .sync_out (src_sync),
    .rise     (src_rise)
  );

  irq_sync_edge #(.WIDTH(1)) u_nmi_sync (
    .clk      (clk),
    .rst_n    (clr_n),
    .async_in (nmi_src),
    .sync_out (nmi_sync),
    .rise     (nmi_rise)
  );

  logic [NUM_SRC-1:0] pend_d, pend_q;
  logic [NUM_SRC-1:0] enable_d, enable_q;
  logic [NUM_SRC-1:0] mode_d, mode_q;
  logic               nmi_en_d, nmi_en_q;
  logic               nmi_pend_d, nmi_pend_q;
  logic               irq_d, irq_q;
  logic               nmi_d, nmi_q;

  logic               sel, wr_en;
  reg_off_e           off;
  logic [NUM_SRC-1:0] w1c, sw_set, src_set, active;
  logic               nmi_w1c;
  logic [7:0]         rdata;

  assign sel     = (addr[15:3] == BASE[15:3]);
  assign wr_en   = sel & ~rw;
  assign dout_en = sel & rw;
  assign off     = reg_off_e'(addr[2:0]);
  assign active  = pend_q & enable_q;

  always_comb begin
    enable_d = enable_q;
    mode_d   = mode_q;
    nmi_en_d = nmi_en_q;
    w1c      = '0;
    sw_set   = '0;
    nmi_w1c  = 1'b0;
    if (wr_en) begin
      case (off)
        OFF_PEND:   w1c      = din;
        OFF_ENABLE: enable_d = din;
        OFF_MODE:   mode_d   = din;
        OFF_NMICTL: begin
          nmi_en_d = din[NMICTL_EN_BIT];
          nmi_w1c  = din[NMICTL_PEND_BIT];
        end
        OFF_SWSET:  sw_set   = din;
        default:    ;
      endcase
    end
  end

  // A set source always wins over a same-cycle clear; for level sources this also
  // means W1C only sticks once the source has gone low.
  always_comb begin
    src_set    = (mode_q & src_rise) | (~mode_q & src_sync) | sw_set;
    pend_d     = src_set | (pend_q & ~w1c);
    nmi_pend_d = (nmi_en_q & nmi_sync & nmi_rise) | (nmi_pend_q & ~nmi_w1c);
    irq_d      = |active;
    nmi_d      = nmi_pend_q;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      pend_q     <= '0;
      enable_q   <= '0;
      mode_q     <= '0;
      nmi_en_q   <= 1'b0;
      nmi_pend_q <= 1'b0;
      irq_q      <= 1'b0;
      nmi_q      <= 1'b0;
    end else begin
      pend_q     <= pend_d;
      enable_q   <= enable_d;
      mode_q     <= mode_d;
      nmi_en_q   <= nmi_en_d;
      nmi_pend_q <= nmi_pend_d;
      irq_q      <= irq_d;
      nmi_q      <= nmi_d;
    end
  end

  always_comb begin
    rdata = '0;
    case (off)
      OFF_PEND:   rdata = pend_q;
      OFF_ENABLE: rdata = enable_q;
      OFF_MODE:   rdata = mode_q;
      OFF_VECTOR: begin
        rdata[VEC_ANY_BIT]             = |active;
        rdata[VEC_IDX_MSB:VEC_IDX_LSB] = lowest_index(active);
      end
      OFF_NMICTL: begin
        rdata[NMICTL_EN_BIT]   = nmi_en_q;
        rdata[NMICTL_PEND_BIT] = nmi_pend_q;
      end
      default:    rdata = '0;
    endcase
  end

  assign dout = dout_en ? rdata : 8'h00;
  assign irq  = irq_q;
  assign nmi  = nmi_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Scoreboard bench for irq_ctrl: register reads are queued with their expected
// value and checked by an independent monitor; irq/nmi follow a reference model.
module tb_irq_ctrl;

  localparam logic [15:0] BASE = 16'hD000;
  localparam logic [15:0] IDLE = 16'h0000;

  logic        clk;
  logic        clr_n;
  logic [15:0] addr;
  logic        rw;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic        dout_en;
  logic [7:0]  irq_src;
  logic        nmi_src;
  logic        irq;
  logic        nmi;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  string      name_q[$];

  irq_ctrl #(.BASE(BASE)) dut (
    .clk     (clk),
    .clr_n   (clr_n),
    .addr    (addr),
    .rw      (rw),
    .din     (din),
    .dout    (dout),
    .dout_en (dout_en),
    .irq_src (irq_src),
    .nmi_src (nmi_src),
    .irq     (irq),
    .nmi     (nmi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a request seen at edge k becomes pending at edge k+2, so the
  // model keeps the input history and looks two samples back.
  logic [7:0] m_pend, m_en, m_mode;
  logic       m_nmi_en, m_nmi_pend, m_irq, m_nmi;
  logic [7:0] src_hist[3];
  logic       nmi_hist[3];

  always @(posedge clk or negedge clr_n) begin : ref_model
    logic [7:0] seen, seen_prev, sw, w1c, new_en, new_mode;
    logic       nmi_w1c, nmi_edge, new_nmi_en;
    int         off;
    if (!clr_n) begin
      m_pend = 0; m_en = 0; m_mode = 0;
      m_nmi_en = 0; m_nmi_pend = 0; m_irq = 0; m_nmi = 0;
      for (int i = 0; i < 3; i++) begin
        src_hist[i] = 0;
        nmi_hist[i] = 0;
      end
    end else begin
      seen       = src_hist[1];
      seen_prev  = src_hist[2];
      nmi_edge   = nmi_hist[1] && !nmi_hist[2];
      sw = 0; w1c = 0; nmi_w1c = 0;
      new_en = m_en; new_mode = m_mode; new_nmi_en = m_nmi_en;
      m_irq = (m_pend & m_en) != 0;
      m_nmi = m_nmi_pend;
      if (!rw && addr >= BASE && addr <= BASE + 16'd7) begin
        off = int'(addr - BASE);
        case (off)
          0: w1c = din;
          1: new_en = din;
          2: new_mode = din;
          4: begin new_nmi_en = din[0]; nmi_w1c = din[1]; end
          5: sw = din;
          default: ;
        endcase
      end
      for (int i = 0; i < 8; i++) begin
        if ((m_mode[i] ? (seen[i] && !seen_prev[i]) : seen[i]) || sw[i]) m_pend[i] = 1'b1;
        else if (w1c[i]) m_pend[i] = 1'b0;
      end
      if (nmi_edge && m_nmi_en) m_nmi_pend = 1'b1;
      else if (nmi_w1c) m_nmi_pend = 1'b0;
      m_en = new_en; m_mode = new_mode; m_nmi_en = new_nmi_en;
      src_hist[2] = src_hist[1]; src_hist[1] = src_hist[0]; src_hist[0] = irq_src;
      nmi_hist[2] = nmi_hist[1]; nmi_hist[1] = nmi_hist[0]; nmi_hist[0] = nmi_src;
    end
  end

  function automatic logic [7:0] model_read(input int off);
    logic [7:0] act;
    logic [7:0] v;
    v = 8'h00;
    case (off)
      0: v = m_pend;
      1: v = m_en;
      2: v = m_mode;
      3: begin
        act = m_pend & m_en;
        for (int i = 7; i >= 0; i--) if (act[i]) v = 8'h80 | 8'(i);
      end
      4: v = {6'b0, m_nmi_pend, m_nmi_en};
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic regWrite(input int off, input logic [7:0] data);
    addr = BASE + 16'(off);
    rw   = 1'b0;
    din  = data;
    tick();
    rw   = 1'b1;
    addr = IDLE;
  endtask

  task automatic regRead(input int off, input logic [7:0] exp, input string name);
    addr = BASE + 16'(off);
    rw   = 1'b1;
    exp_q.push_back(exp);
    name_q.push_back(name);
    tick();
    addr = IDLE;
  endtask

  // Monitor: every presented read is popped against the scoreboard queue.
  initial begin
    logic [7:0] e;
    string      n;
    forever begin
      @(negedge clk);
      #2;
      if (dout_en) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_read: got dout_en=1 dout=%h expected no read", dout);
        end else begin
          e = exp_q.pop_front();
          n = name_q.pop_front();
          checkOutput(n, dout, e);
        end
      end
    end
  end

  task automatic applyStimulus();
    int r;
    int off;
    if ($urandom_range(0, 3) == 0) irq_src = irq_src ^ 8'($urandom);
    if ($urandom_range(0, 3) == 0) nmi_src = ~nmi_src;
    r = $urandom_range(0, 9);
    if (r <= 2) begin
      off = $urandom_range(0, 7);
      regWrite(off, 8'($urandom));
    end else if (r <= 5) begin
      off = $urandom_range(0, 7);
      regRead(off, model_read(off), "rand_read");
    end else begin
      tick();
    end
    checkOutput("rand_irq", {7'b0, irq}, {7'b0, m_irq});
    checkOutput("rand_nmi", {7'b0, nmi}, {7'b0, m_nmi});
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    clr_n = 1'b0; addr = IDLE; rw = 1'b1; din = 8'h00; irq_src = 8'h00; nmi_src = 1'b0;
    repeat (3) tick();
    clr_n = 1'b1;
    tick();

    $display("[TB] reset state");
    for (int i = 0; i < 8; i++) regRead(i, 8'h00, "reset_reg");
    checkOutput("reset_irq", {7'b0, irq}, 8'h00);
    checkOutput("reset_nmi", {7'b0, nmi}, 8'h00);

    $display("[TB] level source");
    regWrite(1, 8'h04);
    regWrite(2, 8'h00);
    irq_src[2] = 1'b1;
    repeat (3) tick();
    checkOutput("lvl_irq_before", {7'b0, irq}, 8'h00);
    regRead(0, 8'h04, "lvl_pend");
    checkOutput("lvl_irq_after", {7'b0, irq}, 8'h01);
    regRead(3, 8'h82, "lvl_vector");
    regWrite(0, 8'h04);
    regRead(0, 8'h04, "lvl_w1c_held");
    irq_src[2] = 1'b0;
    repeat (4) tick();
    regWrite(0, 8'h04);
    regRead(0, 8'h00, "lvl_pend_clear");
    checkOutput("lvl_irq_drop", {7'b0, irq}, 8'h00);

    $display("[TB] edge source and priority");
    regWrite(2, 8'hFF);
    regWrite(1, 8'hA0);
    irq_src[7] = 1'b1; tick(); irq_src[7] = 1'b0;
    irq_src[5] = 1'b1; tick(); irq_src[5] = 1'b0;
    repeat (4) tick();
    regRead(0, 8'hA0, "edge_pend");
    regRead(3, 8'h85, "edge_vector5");
    checkOutput("edge_irq", {7'b0, irq}, 8'h01);
    regWrite(0, 8'h20);
    regRead(3, 8'h87, "edge_vector7");
    regWrite(0, 8'h80);
    checkOutput("edge_irq_hold", {7'b0, irq}, 8'h01);
    tick();
    checkOutput("edge_irq_drop", {7'b0, irq}, 8'h00);

    $display("[TB] masking and software set");
    regWrite(1, 8'h00);
    regWrite(5, 8'h01);
    regRead(0, 8'h01, "sw_pend");
    regRead(3, 8'h00, "sw_vector_masked");
    checkOutput("sw_irq_masked", {7'b0, irq}, 8'h00);
    regWrite(1, 8'h01);
    checkOutput("sw_irq_reg_delay", {7'b0, irq}, 8'h00);
    tick();
    checkOutput("sw_irq_enabled", {7'b0, irq}, 8'h01);

    $display("[TB] reset mid-run");
    #3 clr_n = 1'b0;
    #1 checkOutput("async_reset_irq", {7'b0, irq}, 8'h00);
    tick(); tick();
    clr_n = 1'b1;
    tick();
    regRead(0, 8'h00, "post_reset_pend");
    regRead(1, 8'h00, "post_reset_enable");

    $display("[TB] nmi");
    nmi_src = 1'b1; tick(); nmi_src = 1'b0;
    repeat (4) tick();
    regRead(4, 8'h00, "nmi_gated");
    regWrite(4, 8'h01);
    nmi_src = 1'b1; tick(); nmi_src = 1'b0;
    tick(); tick();
    checkOutput("nmi_before", {7'b0, nmi}, 8'h00);
    tick();
    checkOutput("nmi_after", {7'b0, nmi}, 8'h01);
    regRead(4, 8'h03, "nmi_ctl");
    regWrite(4, 8'h02);
    tick();
    checkOutput("nmi_clear", {7'b0, nmi}, 8'h00);
    regWrite(4, 8'h01);
    nmi_src = 1'b1; tick(); tick();
    regWrite(4, 8'h03);
    nmi_src = 1'b0;
    regRead(4, 8'h03, "nmi_set_wins");
    regWrite(4, 8'h02);

    $display("[TB] decode");
    regWrite(5, 8'h10);
    addr = BASE + 16'd8; rw = 1'b1;
    #2 checkOutput("decode_above_en", {7'b0, dout_en}, 8'h00);
    rw = 1'b0; din = 8'hFF; tick();
    addr = BASE - 16'd1; rw = 1'b1;
    #2 checkOutput("decode_below_en", {7'b0, dout_en}, 8'h00);
    rw = 1'b0; din = 8'hFF; tick();
    rw = 1'b1; addr = IDLE;
    regWrite(6, 8'hFF);
    regWrite(7, 8'hFF);
    regRead(0, 8'h10, "decode_pend_kept");
    regRead(1, 8'h00, "decode_enable_kept");
    regRead(6, 8'h00, "rsvd6");
    regRead(7, 8'h00, "rsvd7");
    regRead(5, 8'h00, "swset_read");
    regWrite(0, 8'hFF);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 600; i++) applyStimulus();
    irq_src = 8'h00; nmi_src = 1'b0;
    repeat (3) tick();

    checkOutput("scoreboard_drain", 8'(exp_q.size()), 8'h00);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Memory-mapped interrupt controller upstream of the 6502 core. It feeds the core's `irq` and `nmi` inputs from eight peripheral interrupt sources and one NMI source. It synchronises, edge-detects, latches, masks and prioritises these requests. The core reads and services them through a small register window on the CPU address/data bus, decoded alongside `ram`.

## Interface
- `BASE`, default 16'hD000: base address of the 8-byte register window, 8-byte aligned.
- `clk` in 1: system clock, the same clock as the core and `ram`.
- `clr_n` in 1: reset, asynchronous, active-low. This is decided.
- `addr` in 16: CPU address bus, `{abh,abl}`.
- `rw` in 1: CPU read/write; 1 = read, 0 = write.
- `din` in 8: write data from the CPU data bus.
- `dout` out 8: read data.
- `dout_en` out 1: drive enable for `dout` onto `dataio`.
- `irq_src` in 8: asynchronous peripheral interrupt requests, active-high.
- `nmi_src` in 1: asynchronous NMI request, active-high.
- `irq` out 1: interrupt request to the core, active-high.
- `nmi` out 1: NMI request to the core, active-high level. The core edge-detects it.

## Operation
- Source conditioning:
  - All `irq_src` bits and `nmi_src` pass through a two-flop synchroniser.
  - A third flop holds the previous synchronised value for rising-edge detection.
- Select: `sel = (addr[15:3] == BASE[15:3])`.
  - Read: `dout_en = sel & rw`.
  - Write: `sel & ~rw`, committed on the rising `clk` edge.
- Register map, by offset:
  - 0 PEND:
    - Read returns `pend[7:0]`.
    - Write is W1C: each 1 in `din` clears the matching bit.
  - 1 ENABLE: RW mask, reset 8'h00.
  - 2 MODE: RW per bit, 1 = edge, 0 = level; reset 8'h00.
  - 3 VECTOR: read-only.
    - Bit 7 = `|(pend & enable)`.
    - Bits 2:0 = index of the lowest-numbered bit set in `pend & enable`; 0 when none.
    - Bits 6:3 = 0. Writes are ignored.
  - 4 NMICTL:
    - Bit 0 = `nmi_en`, RW, reset 0.
    - Bit 1 = `nmi_pend`, read, W1C.
    - Other bits read 0.
  - 5 SWSET: write-only. Each 1 in `din` sets the matching `pend` bit. Reads return 8'h00.
  - 6, 7: read 8'h00; writes ignored.
- Pending update per bit i, evaluated each clock:
  - Level mode: `pend[i]` = synchronised source OR software-set. W1C clears only if the source is low that cycle.
  - Edge mode: set on a synchronised rising edge or SWSET; cleared by W1C. If set and clear occur in the same cycle, set wins.
  - Pending is latched regardless of ENABLE. ENABLE only gates `irq` and VECTOR.
  - A MODE change takes effect next cycle and does not alter existing `pend` bits.
- NMI:
  - A synchronised rising edge of `nmi_src` sets `nmi_pend` only if `nmi_en` = 1.
  - W1C on bit 1 clears it; set wins over a same-cycle clear.
  - Clearing `nmi_en` does not clear `nmi_pend`.
- Outputs:
  - `irq` is registered: `irq <= |(pend & enable)`.
  - `nmi` is registered: `nmi <= nmi_pend`.

## Timing
- Reset values:
  - `pend`, `enable`, `mode`, `nmi_en` and `nmi_pend` = 0.
  - `irq` = 0 and `nmi` = 0.
  - All synchroniser and edge flops = 0.
  - `dout` = 8'h00.
- Reset is asynchronous and takes effect mid-operation. State returns to reset values immediately, regardless of `clk`.
- Source to pending: an asynchronous rising edge of `irq_src` seen at edge k sets `pend` at edge k+2. `irq` rises at edge k+3.
- Register write to output:
  - An ENABLE write at edge k gives `irq` updated at edge k+1.
  - A W1C of the last enabled pend bit at edge k drops `irq` at edge k+1.
- Reads are combinational from current register state within the cycle. There is no read side effect.
- No handshake: the core acknowledges by W1C from its ISR.

## Structure
- A shared package `irq_pkg` holds:
  - register offsets `OFF_PEND`…`OFF_SWSET`
  - `NUM_SRC = 8`
  - VECTOR field positions.
- One natural sub-module, `irq_sync_edge`:
  - Two-flop synchroniser plus edge detector, parameterised on width.
  - Instantiated for the 8 IRQ sources and the 1 NMI source.
- The board instantiates `irq_ctrl` next to `ram`. `dataio` is driven from `dout` under `dout_en`.

## Test plan
- Reset: release `clr_n`. All registers read 8'h00; `irq` = 0 and `nmi` = 0. Assert `clr_n` low mid-run with `irq` = 1 → `irq` = 0 immediately.
- Level source:
  - Setup: ENABLE = 8'h04, MODE = 0. Raise `irq_src[2]` → PEND = 8'h04 after 2 edges, `irq` = 1 one edge later, VECTOR = 8'h82.
  - W1C 8'h04 while the source is high → PEND stays 8'h04.
  - Drop the source → `pend` clears, then `irq` = 0.
- Edge source and priority:
  - Setup: MODE = 8'hFF, ENABLE = 8'hA0. Pulse `irq_src[7]` and `irq_src[5]` for one cycle each → PEND = 8'hA0, VECTOR = 8'h85.
  - W1C 8'h20 → VECTOR = 8'h87.
  - W1C 8'h80 → `irq` = 0.
- Masking and software set:
  - With ENABLE = 0, SWSET 8'h01 → PEND = 8'h01, `irq` = 0, VECTOR = 8'h00.
  - Write ENABLE = 8'h01 → `irq` = 1 next edge.
- NMI:
  - With `nmi_en` = 0, pulse `nmi_src` → NMICTL = 8'h00.
  - Set `nmi_en`, pulse again → NMICTL = 8'h03, `nmi` = 1.
  - W1C 8'h02 → `nmi` = 0.
  - A same-cycle edge and W1C leaves `nmi_pend` = 1.
- Decode: access `BASE+8` and `BASE-1` → `dout_en` = 0 and no register changes. Reads of offsets 6 and 7 return 8'h00.
